interrupt_controller: RTL and testbench

- Sits between the board-level interrupt pins (the 5-bit interruption bus driven into the motherboard) and core0.
- Synchronises the lines, latches edge- or level-type requests into a pending register, and applies a software mask.
- Arbitrates by fixed priority (lowest index wins) and sequences one request through a req/ack/eret handshake with the core.
- A small config port lets the core's CP0/MMIO path program mask and mode and read status.

---
 rtl/intc_pkg.sv | 24 ++
 rtl/intc_if.sv | 24 ++
 rtl/intc_line_sync.sv | 29 ++
 rtl/interrupt_controller.sv | 144 ++++++++++++++
 tb/tb_interrupt_controller.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: state encoding, config
// register map, default sizing and a lowest-set-bit helper.
package intc_pkg;

    localparam int INTC_NUM_IRQ = 5;
    localparam int INTC_ID_W    = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Index of the lowest set bit; 8 when the vector is empty.
    function automatic logic [3:0] first_set(input logic [7:0] v);
        first_set = 4'd8;
        for (int i = 7; i >= 0; i--)
            if (v[i]) first_set = 4'(i);
    endfunction

endpackage

// File: rtl/intc_if.sv
// Core-facing port of the interrupt controller: req/ack/eret handshake plus
// the CP0/MMIO config bus. slave = controller side, master = core side.
interface intc_if #(parameter int ID_W = intc_pkg::INTC_ID_W);

    logic            o_int_req;
    logic [ID_W-1:0] o_int_id;
    logic            i_int_ack;
    logic            i_int_eret;
    logic            i_cfg_we;
    logic [1:0]      i_cfg_addr;
    logic [31:0]     i_cfg_wdata;
    logic [31:0]     o_cfg_rdata;

    modport slave (
        output o_int_req, o_int_id, o_cfg_rdata,
        input  i_int_ack, i_int_eret, i_cfg_we, i_cfg_addr, i_cfg_wdata
    );

    modport master (
        input  o_int_req, o_int_id, o_cfg_rdata,
        output i_int_ack, i_int_eret, i_cfg_we, i_cfg_addr, i_cfg_wdata
    );

endinterface

// File: rtl/intc_line_sync.sv
// One interrupt line: SYNC_STAGES-deep synchroniser followed by a
// previous-value flop, giving the synchronised level and a rise pulse.
module intc_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_pipe <= '0;
            prev_q    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], line};
            prev_q    <= sync_pipe[SYNC_STAGES-1];
        end
    end

    assign level = sync_pipe[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller between the board interrupt pins and
// core0. Optional nesting is enabled by defining NESTED_INT_EN.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int NUM_IRQ     = INTC_NUM_IRQ,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = INTC_ID_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] i_interruption,
    intc_if.slave              bus
);

    logic [NUM_IRQ-1:0] lvl, rise;
    logic [NUM_IRQ-1:0] mask_q, mode_q, pend_q, pend_d, insvc_q;
    logic [NUM_IRQ-1:0] elig, w1c, ack_sel, ack_clr;
    logic [1:0]         state_q;
    logic               req_q;
    logic [ID_W-1:0]    id_q, win_id, status_id;
    logic [3:0]         win_idx;
    logic               any_elig, ack_fire, eret_fire;
    logic [7:0]         isv8;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        intc_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .line  (i_interruption[g]),
            .level (lvl[g]),
            .rise  (rise[g])
        );
    end

    assign elig      = pend_q & mask_q;
    assign any_elig  = |elig;
    assign win_idx   = first_set(8'(elig));
    assign win_id    = win_idx[ID_W-1:0];
    assign ack_fire  = bus.i_int_ack  && (state_q == ST_REQ);
    assign eret_fire = bus.i_int_eret && (state_q == ST_SERVICE);
    assign ack_sel   = NUM_IRQ'(1) << id_q;
    assign ack_clr   = ack_fire ? ack_sel : '0;
    assign w1c       = (bus.i_cfg_we && bus.i_cfg_addr == ADDR_PENDING)
                       ? bus.i_cfg_wdata[NUM_IRQ-1:0] : '0;

    // Edge bits are sticky and a fresh rise wins over any clear; level bits
    // simply follow the synchronised line.
    assign pend_d = (mode_q & ((pend_q & ~w1c & ~ack_clr) | rise))
                  | (~mode_q & lvl);

`ifdef NESTED_INT_EN
    logic [NUM_IRQ-1:0] insvc_lsb;
    logic               nest_ok;
    logic [3:0]         svc_idx;
    assign insvc_lsb = insvc_q & (~insvc_q + NUM_IRQ'(1));
    assign nest_ok   = |(elig & (insvc_lsb - NUM_IRQ'(1)));
    assign svc_idx   = first_set(8'(insvc_q));
    assign status_id = (|insvc_q) ? svc_idx[ID_W-1:0] : '0;
`else
    assign status_id = id_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
            insvc_q <= '0;
            mask_q  <= '0;
            mode_q  <= '1;
            pend_q  <= '0;
        end else begin
            pend_q <= pend_d;
            if (bus.i_cfg_we && bus.i_cfg_addr == ADDR_MASK)
                mask_q <= bus.i_cfg_wdata[NUM_IRQ-1:0];
            if (bus.i_cfg_we && bus.i_cfg_addr == ADDR_MODE)
                mode_q <= bus.i_cfg_wdata[NUM_IRQ-1:0];

            case (state_q)
                ST_IDLE: begin
                    if (any_elig) begin
                        id_q    <= win_id;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_fire) begin
                        req_q   <= 1'b0;
                        insvc_q <= insvc_q | ack_sel;
                        state_q <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (eret_fire) begin
`ifdef NESTED_INT_EN
                        insvc_q <= insvc_q & ~insvc_lsb;
                        state_q <= |(insvc_q & ~insvc_lsb) ? ST_SERVICE : ST_IDLE;
`else
                        insvc_q <= '0;
                        state_q <= ST_IDLE;
`endif
                    end
`ifdef NESTED_INT_EN
                    else if (nest_ok) begin
                        id_q    <= win_id;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign isv8 = 8'(insvc_q);

    always_comb begin
        bus.o_cfg_rdata = '0;
        case (bus.i_cfg_addr)
            ADDR_MASK:    bus.o_cfg_rdata[NUM_IRQ-1:0] = mask_q;
            ADDR_MODE:    bus.o_cfg_rdata[NUM_IRQ-1:0] = mode_q;
            ADDR_PENDING: bus.o_cfg_rdata[NUM_IRQ-1:0] = pend_q;
            default: begin
                bus.o_cfg_rdata[1:0]  = state_q;
                bus.o_cfg_rdata[8:2]  = isv8[6:0];
                bus.o_cfg_rdata[15:9] = 7'(status_id);
            end
        endcase
    end

    assign bus.o_int_req = req_q;
    assign bus.o_int_id  = id_q;

    logic unused_bits;
`ifdef NESTED_INT_EN
    assign unused_bits = ^{bus.i_cfg_wdata, win_idx, isv8, svc_idx};
`else
    assign unused_bits = ^{bus.i_cfg_wdata, win_idx, isv8};
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_interrupt_controller;
    import intc_pkg::*;

    localparam int N  = 5;
    localparam int SS = 2;
    localparam int IW = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] lines = '0;

    intc_if #(.ID_W(IW)) bus();

    interrupt_controller #(.NUM_IRQ(N), .SYNC_STAGES(SS), .ID_W(IW)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_interruption (lines),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: line samples are delayed SS edges, then the spec's
    // pending/arbitration/handshake rules are applied with plain loops.
    logic [N-1:0] hist [SS+1];
    logic [N-1:0] m_pend, m_mask, m_mode, m_insvc;
    logic         m_req;
    int           m_id, m_phase;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return N;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [1:0] a);
        int sid;
`ifdef NESTED_INT_EN
        sid = (m_insvc != 0) ? lowest(m_insvc) : 0;
`else
        sid = m_id;
`endif
        case (a)
            2'd0:    return 32'(m_mask);
            2'd1:    return 32'(m_mode);
            2'd2:    return 32'(m_pend);
            default: return 32'(m_phase) | (32'(m_insvc) << 2) | (32'(sid) << 9);
        endcase
    endfunction

    task automatic model_step();
        logic [N-1:0] lv, pv, np, elig;
        int lo;
        if (reset) begin
            m_pend = '0; m_mask = '0; m_mode = '1; m_insvc = '0;
            m_req = 1'b0; m_id = 0; m_phase = 0;
            for (int k = 0; k <= SS; k++) hist[k] = '0;
            return;
        end
        lv   = hist[SS-1];
        pv   = hist[SS];
        elig = m_pend & m_mask;
        for (int i = 0; i < N; i++) begin
            if (m_mode[i]) begin
                np[i] = m_pend[i];
                if (bus.i_cfg_we && bus.i_cfg_addr == 2'd2 && bus.i_cfg_wdata[i]) np[i] = 1'b0;
                if (m_phase == 1 && bus.i_int_ack && m_id == i) np[i] = 1'b0;
                if (lv[i] && !pv[i]) np[i] = 1'b1;
            end else begin
                np[i] = lv[i];
            end
        end
        lo = lowest(elig);
        case (m_phase)
            0: if (lo < N) begin m_req = 1'b1; m_id = lo; m_phase = 1; end
            1: if (bus.i_int_ack) begin m_req = 1'b0; m_insvc[m_id] = 1'b1; m_phase = 2; end
            default: begin
                if (bus.i_int_eret) begin
`ifdef NESTED_INT_EN
                    m_insvc[lowest(m_insvc)] = 1'b0;
                    m_phase = (m_insvc != 0) ? 2 : 0;
`else
                    m_insvc = '0;
                    m_phase = 0;
`endif
                end
`ifdef NESTED_INT_EN
                else if (lo < lowest(m_insvc)) begin m_req = 1'b1; m_id = lo; m_phase = 1; end
`endif
            end
        endcase
        m_pend = np;
        if (bus.i_cfg_we && bus.i_cfg_addr == 2'd0) m_mask = bus.i_cfg_wdata[N-1:0];
        if (bus.i_cfg_we && bus.i_cfg_addr == 2'd1) m_mode = bus.i_cfg_wdata[N-1:0];
        for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = lines;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("req", 32'(bus.o_int_req), 32'(m_req));
        chk("id", 32'(bus.o_int_id), m_id);
        chk("rdata", bus.o_cfg_rdata, exp_rdata(bus.i_cfg_addr));
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        bus.i_cfg_we = 1'b1; bus.i_cfg_addr = a; bus.i_cfg_wdata = d;
        tick();
        bus.i_cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        bus.i_cfg_addr = a;
        #1;
        chk(tag, bus.o_cfg_rdata, exp);
    endtask

    task automatic ack();  bus.i_int_ack = 1'b1;  tick(); bus.i_int_ack = 1'b0;  endtask
    task automatic eret(); bus.i_int_eret = 1'b1; tick(); bus.i_int_eret = 1'b0; endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!bus.o_int_req && n < 20) begin tick(); n++; end
        chk(tag, 32'(bus.o_int_req), 32'd1);
    endtask

    initial begin
        bus.i_int_ack = 1'b0; bus.i_int_eret = 1'b0; bus.i_cfg_we = 1'b0;
        bus.i_cfg_addr = 2'd0; bus.i_cfg_wdata = '0;
        tick(); tick();
        reset = 1'b0;
        rd(2'd1, "rst_mode", 32'h1F);
        rd(2'd3, "rst_status", 32'h0);
        chk("rst_req", 32'(bus.o_int_req), 32'd0);

        // 1: single edge request, latency and handshake
        cfg_wr(2'd0, 32'h1F);
        lines = 5'b01000;
        repeat (3) tick();
        chk("t1_early", 32'(bus.o_int_req), 32'd0);
        tick();
        chk("t1_req", 32'(bus.o_int_req), 32'd1);
        chk("t1_id", 32'(bus.o_int_id), 32'd3);
        ack();
        chk("t1_ack_req", 32'(bus.o_int_req), 32'd0);
        rd(2'd3, "t1_status_svc", 32'h622);
        eret();
        chk("t1_status_idle", bus.o_cfg_rdata & 32'h3, 32'h0);
        lines = '0;
        repeat (3) tick();

        // 2: simultaneous rise, lowest index first, then the other
        lines = 5'b10010;
        repeat (4) tick();
        chk("t2_id1", 32'(bus.o_int_id), 32'd1);
        ack(); eret();
        chk("t2_gap", 32'(bus.o_int_req), 32'd0);
        tick();
        chk("t2_req4", 32'(bus.o_int_req), 32'd1);
        chk("t2_id4", 32'(bus.o_int_id), 32'd4);
        ack(); eret();
        lines = '0;
        repeat (3) tick();

        // 3: masked pending, unmask, W1C while in REQ
        cfg_wr(2'd0, 32'h0);
        lines = 5'b00100; tick();
        lines = '0; tick(); tick();
        rd(2'd2, "t3_pend", 32'h04);
        chk("t3_noreq", 32'(bus.o_int_req), 32'd0);
        cfg_wr(2'd0, 32'h04);
        tick();
        chk("t3_id2", 32'(bus.o_int_id), 32'd2);
        cfg_wr(2'd2, 32'h04);
        chk("t3_hold_req", 32'(bus.o_int_req), 32'd1);
        chk("t3_hold_id", 32'(bus.o_int_id), 32'd2);
        rd(2'd2, "t3_pend_clr", 32'h0);
        ack(); eret();

        // 4: W1C and new rise on the same bit in the same cycle
        cfg_wr(2'd0, 32'h0);
        lines = 5'b00001; tick();
        lines = '0; tick(); tick();
        lines = 5'b00001; tick(); tick();
        cfg_wr(2'd2, 32'h01);
        rd(2'd2, "t4_set_wins", 32'h01);
        cfg_wr(2'd2, 32'h01);
        rd(2'd2, "t4_w1c", 32'h00);
        lines = '0;
        repeat (3) tick();

        // 5: level mode re-request and drop
        cfg_wr(2'd0, 32'h02);
        cfg_wr(2'd1, 32'h1D);
        lines = 5'b00010;
        wait_req("t5_req");
        chk("t5_id", 32'(bus.o_int_id), 32'd1);
        ack(); eret(); tick();
        chk("t5_rereq", 32'(bus.o_int_req), 32'd1);
        lines = '0;
        repeat (3) tick();
        rd(2'd2, "t5_pend_lvl", 32'h0);
        ack(); eret(); tick(); tick();
        chk("t5_noreq", 32'(bus.o_int_req), 32'd0);
        cfg_wr(2'd1, 32'h1F);

        // 6: reset during SERVICE
        cfg_wr(2'd0, 32'h1F);
        lines = 5'b01000;
        wait_req("t6_req");
        ack();
        lines = '0;
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_req", 32'(bus.o_int_req), 32'd0);
        rd(2'd2, "t6_pend", 32'h0);
        rd(2'd0, "t6_mask", 32'h0);
        rd(2'd3, "t6_status", 32'h0);
        repeat (3) tick();

`ifdef NESTED_INT_EN
        cfg_wr(2'd0, 32'h1F);
        lines = 5'b01000;
        wait_req("n_req3");
        ack();
        lines = 5'b01001;
        wait_req("n_req0");
        chk("n_id0", 32'(bus.o_int_id), 32'd0);
        ack(); eret();
        rd(2'd3, "n_back_svc", 32'h622);
        eret();
        rd(2'd3, "n_idle", 32'h0);
        lines = '0;
        reset = 1'b1; tick(); reset = 1'b0;
`endif

        // randomized traffic checked against the model every cycle
        for (int c = 0; c < 800; c++) begin
            lines = lines ^ (N'($urandom) & N'($urandom) & N'($urandom));
            bus.i_int_ack   = ($urandom_range(0, 3) == 0);
            bus.i_int_eret  = ($urandom_range(0, 4) == 0);
            bus.i_cfg_we    = ($urandom_range(0, 9) == 0);
            bus.i_cfg_addr  = 2'($urandom);
            bus.i_cfg_wdata = $urandom;
            reset           = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
